// File: rtl/rt_program_sequencer.sv
// Small register-file program sequencer: loads four operand registers, runs up to
// DEPTH two-operand instructions from a local program memory, then publishes the
// register file on y3..y0 together with a one-cycle done pulse.
module rt_program_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b0,
    input  logic             prog_we,
    input  logic [3:0]       prog_addr,
    input  logic [7:0]       prog_data,
    input  logic [4:0]       prog_len,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y0
);

    // pc/len share the prog_len width; the memory index only needs enough bits for DEPTH.
    localparam int unsigned LenW = 5;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Opcodes
    localparam logic [2:0] OpXor = 3'b000;
    localparam logic [2:0] OpAnd = 3'b001;
    localparam logic [2:0] OpOr  = 3'b010;
    localparam logic [2:0] OpAdd = 3'b011;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpMov = 3'b101;
    localparam logic [2:0] OpNot = 3'b110;
    localparam logic [2:0] OpNop = 3'b111;

    // Memory keeps only bits [7:1]; the reserved bit 0 is never stored.
    // 7'h70 is the stored form of 8'hE0 (NOP r0,r0).
    localparam logic [6:0] NopWord = 7'h70;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExec,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [LenW-1:0]   pc_q, pc_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [WIDTH-1:0]  r_q [4];
    logic [WIDTH-1:0]  r_d [4];
    logic [WIDTH-1:0]  y_q [4];
    logic [WIDTH-1:0]  y_d [4];
    logic [6:0]        mem_q [DEPTH];

    logic [6:0]        instr;
    logic [2:0]        op;
    logic [1:0]        dst;
    logic [1:0]        src;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  alu_res;
    logic              wr_en;

    assign instr = mem_q[pc_q[AW-1:0]];
    assign op    = instr[6:4];
    assign dst   = instr[3:2];
    assign src   = instr[1:0];

    // Program writes are only accepted while not running and for in-range addresses.
    assign wr_en = prog_we && ((state_q == StIdle) || (state_q == StDone)) &&
                   (32'(prog_addr) < DEPTH);

    // Program memory: reset fills with NOP, writes go to the addressed entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= NopWord;
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (prog_addr == 4'(i)) begin
                    mem_q[i] <= prog_data[7:1];
                end
            end
        end
    end

    // ALU: both operands are pre-edge register values, so dst==src is well defined.
    always_comb begin
        opa     = r_q[dst];
        opb     = r_q[src];
        alu_res = opa;
        unique case (op)
            OpXor: alu_res = opa ^ opb;
            OpAnd: alu_res = opa & opb;
            OpOr:  alu_res = opa | opb;
            OpAdd: alu_res = opa + opb;
            OpSub: alu_res = opa - opb;
            OpMov: alu_res = opb;
            OpNot: alu_res = ~opb;
            OpNop: alu_res = opa;
        endcase
    end

    // Next-state: FSM sequencing, register file updates and result capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        r_d     = r_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = (32'(prog_len) > DEPTH) ? LenW'(DEPTH) : prog_len;
                    pc_d    = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                r_d[0] = a0;
                r_d[1] = a1;
                r_d[2] = b0;
                r_d[3] = b1;
                if (len_q != '0) begin
                    state_d = StExec;
                end else begin
                    state_d = StDone;
                    y_d     = r_d;
                end
            end
            StExec: begin
                r_d[dst] = alu_res;
                pc_d     = pc_q + LenW'(1);
                // Results include the final instruction's write.
                if (pc_q == len_q - LenW'(1)) begin
                    state_d = StDone;
                    y_d     = r_d;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            r_q     <= r_d;
            y_q     <= y_d;
        end
    end

    assign busy = (state_q == StLoad) || (state_q == StExec);
    assign done = (state_q == StDone);
    assign y0   = y_q[0];
    assign y1   = y_q[1];
    assign y2   = y_q[2];
    assign y3   = y_q[3];

endmodule
